program_loader: RTL
===================

# program_loader

Serial boot loader that fills the processor's instruction memory through its write port, then releases the processor from reset. It is the writer side of the program-memory interface, which the processor core only reads. A byte stream (framed: sync, 16-bit word count, big-endian instruction words, checksum) arrives on an 8-bit strobed input. The loader holds the core in reset until a frame passes its checksum.

## Interface
Parameters:
- ADDR_WIDTH, 11, instruction-memory word-address width (2048 words); must be ≤16
- SYNC_BYTE, 8'hA5, frame start marker
- TIMEOUT_CYCLES, 1000000, maximum idle cycles between bytes inside a frame

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe; rx_data is valid this cycle
- bypass  in  1  in IDLE, skip loading and run the existing memory contents
- imem_we  out  1  instruction-memory write enable, one-cycle pulse
- imem_addr  out  ADDR_WIDTH  word address of the write
- imem_wdata  out  32  instruction word
- cpu_reset  out  1  reset to the processor core; high while not in RUN
- load_done  out  1  high in RUN
- load_error  out  1  high in ERROR

## Operation
- States: IDLE, LEN_HI, LEN_LO, DATA, CHECK, RUN, ERROR. Only accepted bytes (rx_valid=1) advance the FSM.
- IDLE:
  - SYNC_BYTE → LEN_HI.
  - Any other byte is ignored.
  - bypass=1 with no rx_valid → RUN. If SYNC_BYTE and bypass arrive in the same cycle, the sync byte wins.
- LEN_HI / LEN_LO: capture the word count N[15:8], then N[7:0]. On the LEN_LO byte:
  - N=0 or N>2^ADDR_WIDTH → ERROR.
  - Otherwise → DATA, with word index=0, byte index=0, checksum=0.
- DATA:
  - Each byte shifts into a 32-bit assembly register. The first byte lands in bits [31:24] (big-endian).
  - checksum += byte (8-bit, modulo 256).
  - On the 4th byte of a word: write the word at imem_addr=word index, increment the word index, reset the byte index.
  - After word N-1 is written → CHECK.
- CHECK: byte == checksum → RUN; otherwise → ERROR. The checksum covers data bytes only (not sync or length).
- RUN:
  - cpu_reset=0, load_done=1.
  - All rx bytes and bypass are ignored.
  - Only reset leaves RUN.
- ERROR:
  - load_error=1, cpu_reset=1.
  - SYNC_BYTE → LEN_HI and clears load_error. Other bytes are ignored.
  - Words already written stay in memory and are overwritten by the next frame.
- Timeout:
  - An idle counter runs in LEN_HI, LEN_LO, DATA, and CHECK. It clears on every accepted byte and on state entry.
  - Reaching TIMEOUT_CYCLES → ERROR.
  - rx_valid in the expiry cycle wins: the byte is processed and the counter cleared.
- Reset mid-frame: the partial word is discarded, no write occurs, and the FSM returns to IDLE.

## Timing
- Reset values: state=IDLE, imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset=1, load_done=0, load_error=0; internal counters and checksum are 0.
- Reset dominates rx_valid and bypass in the same cycle.
- All outputs are registered.
  - imem_we pulses high for exactly the one cycle after the rx_valid cycle of a word's 4th byte.
  - imem_addr and imem_wdata are valid in that same cycle and hold their value afterwards.
- Back-to-back rx_valid (every cycle) is supported with no byte loss. The write throughput is one word per 4 cycles.
- Entering RUN: cpu_reset falls and load_done rises one cycle after the accepted checksum byte (or one cycle after bypass is sampled in IDLE).
- load_error rises one cycle after the failing byte or the timeout expiry.
- The timeout fires when the counter reaches TIMEOUT_CYCLES idle cycles since the last accepted byte.

## Test plan
- Good frame: A5 00 01 20 08 00 05 2D (back-to-back) → single imem_we pulse with addr 0 and data 32'h20080005; cpu_reset=0 and load_done=1 one cycle after 2D.
- Two-word frame with gaps between bytes: A5 00 02 | 01 02 03 04 | 05 06 07 08 | 24 → writes 0x01020304 at 0 and 0x05060708 at 1; RUN entered.
- Bad checksum then recovery: A5 00 01 20 08 00 05 2E → load_error=1, cpu_reset stays 1. Then the good frame → load_error=0, RUN.
- Length bounds with ADDR_WIDTH=11: A5 00 00 → ERROR after the 3rd byte. A5 08 01 → ERROR. A5 08 00 → accepted (DATA).
- Timeout with TIMEOUT_CYCLES=16: A5 00 01 20 08, then idle → load_error rises after 16 idle cycles, with no imem_we. A byte arriving in the expiry cycle instead → no error.
- Reset mid-DATA after 2 bytes → all outputs at reset values next cycle, no write. Separately, bypass=1 in IDLE → cpu_reset=0 next cycle with zero writes. A later SYNC_BYTE in RUN is ignored.

Source files
------------

// File: rtl/program_loader.sv
// Serial boot loader: receives a framed byte stream, writes the instruction
// memory word by word, and releases the core once the checksum matches.
module program_loader #(
  parameter int         ADDR_WIDTH     = 11,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  input  logic                  bypass,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_reset,
  output logic                  load_done,
  output logic                  load_error
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LEN_HI = 3'd1;
  localparam logic [2:0] LEN_LO = 3'd2;
  localparam logic [2:0] DATA   = 3'd3;
  localparam logic [2:0] CHECK  = 3'd4;
  localparam logic [2:0] RUN    = 3'd5;
  localparam logic [2:0] ERROR  = 3'd6;

  // Counter only needs to reach TIMEOUT_CYCLES-1; the next idle cycle expires.
  localparam int              CNT_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [16:0]      MAX_WORDS = 17'd1 << ADDR_WIDTH;

  logic [2:0]            state_reg, state_next;
  logic [7:0]            len_hi_reg, len_hi_next;
  logic [15:0]           len_reg, len_next;
  logic [16:0]           word_idx_reg, word_idx_next;
  logic [1:0]            byte_idx_reg, byte_idx_next;
  logic [23:0]           asm_reg, asm_next;
  logic [7:0]            checksum_reg, checksum_next;
  logic [CNT_W-1:0]      idle_cnt_reg, idle_cnt_next;
  logic                  we_next;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic [31:0]           wdata_next;

  logic [15:0] frame_len;
  logic [16:0] word_idx_inc;
  logic        active;

  assign frame_len    = {len_hi_reg, rx_data};
  assign word_idx_inc = word_idx_reg + 17'd1;
  assign active       = (state_reg == LEN_HI) || (state_reg == LEN_LO) ||
                        (state_reg == DATA)   || (state_reg == CHECK);

  always_comb begin
    state_next    = state_reg;
    len_hi_next   = len_hi_reg;
    len_next      = len_reg;
    word_idx_next = word_idx_reg;
    byte_idx_next = byte_idx_reg;
    asm_next      = asm_reg;
    checksum_next = checksum_reg;
    idle_cnt_next = '0;
    we_next       = 1'b0;
    addr_next     = imem_addr;
    wdata_next    = imem_wdata;

    case (state_reg)
      IDLE: begin
        if (rx_valid) begin
          if (rx_data == SYNC_BYTE) state_next = LEN_HI;
        end else if (bypass) begin
          state_next = RUN;
        end
      end
      LEN_HI: begin
        if (rx_valid) begin
          len_hi_next = rx_data;
          state_next  = LEN_LO;
        end
      end
      LEN_LO: begin
        if (rx_valid) begin
          if ((frame_len == 16'd0) || ({1'b0, frame_len} > MAX_WORDS)) begin
            state_next = ERROR;
          end else begin
            state_next    = DATA;
            len_next      = frame_len;
            word_idx_next = '0;
            byte_idx_next = '0;
            checksum_next = '0;
          end
        end
      end
      DATA: begin
        if (rx_valid) begin
          asm_next      = {asm_reg[15:0], rx_data};
          checksum_next = checksum_reg + rx_data;
          byte_idx_next = byte_idx_reg + 2'd1;
          if (byte_idx_reg == 2'd3) begin
            we_next       = 1'b1;
            addr_next     = word_idx_reg[ADDR_WIDTH-1:0];
            wdata_next    = {asm_reg, rx_data};
            word_idx_next = word_idx_inc;
            if (word_idx_inc == {1'b0, len_reg}) state_next = CHECK;
          end
        end
      end
      CHECK: begin
        if (rx_valid) state_next = (rx_data == checksum_reg) ? RUN : ERROR;
      end
      RUN: begin
      end
      ERROR: begin
        if (rx_valid && (rx_data == SYNC_BYTE)) state_next = LEN_HI;
      end
      default: state_next = IDLE;
    endcase

    // An accepted byte always clears the counter, so it wins over expiry.
    if (active && !rx_valid) begin
      if (idle_cnt_reg == CNT_LAST) state_next = ERROR;
      else idle_cnt_next = idle_cnt_reg + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      len_hi_reg   <= '0;
      len_reg      <= '0;
      word_idx_reg <= '0;
      byte_idx_reg <= '0;
      asm_reg      <= '0;
      checksum_reg <= '0;
      idle_cnt_reg <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      cpu_reset    <= 1'b1;
      load_done    <= 1'b0;
      load_error   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      len_hi_reg   <= len_hi_next;
      len_reg      <= len_next;
      word_idx_reg <= word_idx_next;
      byte_idx_reg <= byte_idx_next;
      asm_reg      <= asm_next;
      checksum_reg <= checksum_next;
      idle_cnt_reg <= idle_cnt_next;
      imem_we      <= we_next;
      imem_addr    <= addr_next;
      imem_wdata   <= wdata_next;
      cpu_reset    <= (state_next != RUN);
      load_done    <= (state_next == RUN);
      load_error   <= (state_next == ERROR);
    end
  end

endmodule
